// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 8x16 register file: merges ALU and load writebacks
// into an in-order FIFO, drains one entry per cycle, and offers bypass lookups.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rw_en,
  output logic [ADDR_W-1:0] rw_dest,
  output logic [DATA_W-1:0] rw_data,
  input  logic [ADDR_W-1:0] byp_addr_1,
  input  logic [ADDR_W-1:0] byp_addr_2,
  output logic              byp_hit_1,
  output logic [DATA_W-1:0] byp_data_1,
  output logic              byp_hit_2,
  output logic [DATA_W-1:0] byp_data_2,
  output logic [ADDR_W:0]   pending
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;

  logic [CNT_W-1:0]  free_c;
  logic              mem_push_c;
  logic              alu_push_c;
  logic              pop_c;
  logic [PTR_W-1:0]  alu_slot_c;
  logic [PTR_W-1:0]  head_d;
  logic [PTR_W-1:0]  tail_d;
  logic [CNT_W-1:0]  pending_d;
  logic [PTR_W-1:0]  byp_idx_c;

  // Readiness looks at occupancy before this cycle's pop; load wins the last slot.
  assign free_c     = CNT_W'(DEPTH) - pending;
  assign mem_ready  = rst_n && (free_c >= CNT_W'(1));
  assign alu_ready  = rst_n && ((free_c >= CNT_W'(2)) ||
                                ((free_c == CNT_W'(1)) && !mem_valid));
  assign mem_push_c = mem_valid && mem_ready;
  assign alu_push_c = alu_valid && alu_ready;
  assign pop_c      = (pending != '0);
  assign alu_slot_c = mem_push_c ? (tail_q + PTR_W'(1)) : tail_q;

  always_comb begin
    head_d    = pop_c ? (head_q + PTR_W'(1)) : head_q;
    tail_d    = tail_q + PTR_W'(mem_push_c) + PTR_W'(alu_push_c);
    pending_d = pending + CNT_W'(mem_push_c) + CNT_W'(alu_push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      pending <= '0;
      rw_en   <= 1'b0;
      rw_dest <= '0;
      rw_data <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      pending <= pending_d;
      rw_en   <= pop_c;
      if (pop_c) begin
        rw_dest <= dest_q[head_q];
        rw_data <= data_q[head_q];
      end
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (mem_push_c) begin
        dest_q[tail_q] <= mem_dest;
        data_q[tail_q] <= mem_data;
      end
      if (alu_push_c) begin
        dest_q[alu_slot_c] <= alu_dest;
        data_q[alu_slot_c] <= alu_data;
      end
    end
  end

  // Oldest-to-youngest scan with later matches overriding, so the youngest wins.
  always_comb begin
    byp_hit_1  = rw_en && (rw_dest == byp_addr_1);
    byp_data_1 = byp_hit_1 ? rw_data : '0;
    byp_hit_2  = rw_en && (rw_dest == byp_addr_2);
    byp_data_2 = byp_hit_2 ? rw_data : '0;
    byp_idx_c  = head_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      byp_idx_c = head_q + PTR_W'(k);
      if (CNT_W'(k) < pending) begin
        if (dest_q[byp_idx_c] == byp_addr_1) begin
          byp_hit_1  = 1'b1;
          byp_data_1 = data_q[byp_idx_c];
        end
        if (dest_q[byp_idx_c] == byp_addr_2) begin
          byp_hit_2  = 1'b1;
          byp_data_2 = data_q[byp_idx_c];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and scoreboard-checked stimulus for rf_write_arbiter.
module tb_rf_write_arbiter;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_dest, mem_dest;
  logic [DW-1:0] alu_data, mem_data;
  logic          rw_en;
  logic [AW-1:0] rw_dest;
  logic [DW-1:0] rw_data;
  logic [AW-1:0] byp_addr_1, byp_addr_2;
  logic          byp_hit_1, byp_hit_2;
  logic [DW-1:0] byp_data_1, byp_data_2;
  logic [AW:0]   pending;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .rw_en(rw_en), .rw_dest(rw_dest), .rw_data(rw_data),
    .byp_addr_1(byp_addr_1), .byp_addr_2(byp_addr_2),
    .byp_hit_1(byp_hit_1), .byp_data_1(byp_data_1),
    .byp_hit_2(byp_hit_2), .byp_data_2(byp_data_2),
    .pending(pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
    mem_valid = v; mem_dest = d; mem_data = x;
  endtask

  task automatic set_alu(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
    alu_valid = v; alu_dest = d; alu_data = x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_mem(1'b1, 3'd1, 16'h1234);
    set_alu(1'b1, 3'd2, 16'h5678);
    tick(); tick();
    vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_alu_ready got=%b exp=0", alu_ready); end
    vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mem_ready got=%b exp=0", mem_ready); end
    vectors++; if (pending !== 4'd0) begin miscompares++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    vectors++; if ({rw_en, rw_dest, rw_data} !== 20'd0) begin miscompares++; $display("FAIL reset_rw got=%b/%0d/%h exp=0/0/0000", rw_en, rw_dest, rw_data); end
    set_mem(1'b0, 3'd0, 16'h0);
    set_alu(1'b0, 3'd0, 16'h0);
    rst_n = 1'b1;
    tick();
    vectors++; if (pending !== 4'd0) begin miscompares++; $display("FAIL post_reset_pending got=%0d exp=0", pending); end
  endtask

  task automatic test_single_push();
    set_alu(1'b1, 3'd3, 16'hBEEF);
    #1;
    vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL single_alu_ready got=%b exp=1", alu_ready); end
    tick();
    set_alu(1'b0, 3'd0, 16'h0);
    vectors++; if (pending !== 4'd1 || rw_en !== 1'b0) begin miscompares++; $display("FAIL single_edge1 pending=%0d rw_en=%b exp=1/0", pending, rw_en); end
    tick();
    vectors++; if ({rw_en, rw_dest, rw_data} !== {1'b1, 3'd3, 16'hBEEF}) begin miscompares++; $display("FAIL single_write got=%b/%0d/%h exp=1/3/beef", rw_en, rw_dest, rw_data); end
    vectors++; if (pending !== 4'd0) begin miscompares++; $display("FAIL single_pending got=%0d exp=0", pending); end
    tick();
    vectors++; if ({rw_en, rw_dest, rw_data} !== {1'b0, 3'd3, 16'hBEEF}) begin miscompares++; $display("FAIL single_idle got=%b/%0d/%h exp=0/3/beef", rw_en, rw_dest, rw_data); end
  endtask

  task automatic test_simultaneous();
    set_mem(1'b1, 3'd2, 16'h1111);
    set_alu(1'b1, 3'd5, 16'h2222);
    #1;
    vectors++; if ({mem_ready, alu_ready} !== 2'b11) begin miscompares++; $display("FAIL simul_ready got=%b%b exp=11", mem_ready, alu_ready); end
    tick();
    set_mem(1'b0, 3'd0, 16'h0);
    set_alu(1'b0, 3'd0, 16'h0);
    vectors++; if (pending !== 4'd2 || rw_en !== 1'b0) begin miscompares++; $display("FAIL simul_edge1 pending=%0d rw_en=%b exp=2/0", pending, rw_en); end
    tick();
    vectors++; if ({rw_en, rw_dest, rw_data} !== {1'b1, 3'd2, 16'h1111}) begin miscompares++; $display("FAIL simul_first got=%b/%0d/%h exp=1/2/1111", rw_en, rw_dest, rw_data); end
    tick();
    vectors++; if ({rw_en, rw_dest, rw_data} !== {1'b1, 3'd5, 16'h2222}) begin miscompares++; $display("FAIL simul_second got=%b/%0d/%h exp=1/5/2222", rw_en, rw_dest, rw_data); end
    tick();
    vectors++; if (rw_en !== 1'b0 || pending !== 4'd0) begin miscompares++; $display("FAIL simul_done rw_en=%b pending=%0d exp=0/0", rw_en, pending); end
  endtask

  // Draining one per cycle while both producers push caps occupancy at DEPTH-1.
  task automatic test_fill();
    logic [AW-1:0] ed [3];
    logic [DW-1:0] ex [3];
    logic [AW:0]   ep [3];
    ed[0] = 3'd4; ex[0] = 16'h2001; ep[0] = 4'd2;
    ed[1] = 3'd5; ex[1] = 16'h1002; ep[1] = 4'd1;
    ed[2] = 3'd6; ex[2] = 16'h2002; ep[2] = 4'd0;
    set_mem(1'b1, 3'd1, 16'h1000);
    set_alu(1'b1, 3'd2, 16'h2000);
    #1;
    vectors++; if ({mem_ready, alu_ready} !== 2'b11) begin miscompares++; $display("FAIL fill_a_ready got=%b%b exp=11", mem_ready, alu_ready); end
    tick();
    vectors++; if (pending !== 4'd2) begin miscompares++; $display("FAIL fill_a_pending got=%0d exp=2", pending); end
    set_mem(1'b1, 3'd3, 16'h1001);
    set_alu(1'b1, 3'd4, 16'h2001);
    #1;
    vectors++; if ({mem_ready, alu_ready} !== 2'b11) begin miscompares++; $display("FAIL fill_b_ready got=%b%b exp=11", mem_ready, alu_ready); end
    tick();
    vectors++; if (pending !== 4'd3 || {rw_en, rw_dest, rw_data} !== {1'b1, 3'd1, 16'h1000}) begin miscompares++; $display("FAIL fill_b got pending=%0d rw=%b/%0d/%h exp=3 1/1/1000", pending, rw_en, rw_dest, rw_data); end
    set_mem(1'b1, 3'd5, 16'h1002);
    set_alu(1'b1, 3'd6, 16'h2002);
    #1;
    vectors++; if ({mem_ready, alu_ready} !== 2'b10) begin miscompares++; $display("FAIL fill_c_ready got=%b%b exp=10", mem_ready, alu_ready); end
    tick();
    vectors++; if (pending !== 4'd3 || {rw_en, rw_dest, rw_data} !== {1'b1, 3'd2, 16'h2000}) begin miscompares++; $display("FAIL fill_c got pending=%0d rw=%b/%0d/%h exp=3 1/2/2000", pending, rw_en, rw_dest, rw_data); end
    set_mem(1'b0, 3'd0, 16'h0);
    #1;
    vectors++; if ({mem_ready, alu_ready} !== 2'b11) begin miscompares++; $display("FAIL fill_d_ready got=%b%b exp=11", mem_ready, alu_ready); end
    tick();
    set_alu(1'b0, 3'd0, 16'h0);
    vectors++; if (pending !== 4'd3 || {rw_en, rw_dest, rw_data} !== {1'b1, 3'd3, 16'h1001}) begin miscompares++; $display("FAIL fill_d got pending=%0d rw=%b/%0d/%h exp=3 1/3/1001", pending, rw_en, rw_dest, rw_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (pending !== ep[i] || {rw_en, rw_dest, rw_data} !== {1'b1, ed[i], ex[i]}) begin miscompares++; $display("FAIL fill_drain%0d got pending=%0d rw=%b/%0d/%h exp=%0d 1/%0d/%h", i, pending, rw_en, rw_dest, rw_data, ep[i], ed[i], ex[i]); end
    end
    tick();
    vectors++; if (rw_en !== 1'b0) begin miscompares++; $display("FAIL fill_idle rw_en got=%b exp=0", rw_en); end
  endtask

  task automatic test_bypass();
    byp_addr_1 = 3'd4;
    byp_addr_2 = 3'd6;
    set_alu(1'b1, 3'd4, 16'h0001);
    #1;
    vectors++; if (byp_hit_1 !== 1'b0 || byp_data_1 !== 16'h0) begin miscompares++; $display("FAIL byp_incoming got=%b/%h exp=0/0000", byp_hit_1, byp_data_1); end
    tick();
    set_alu(1'b1, 3'd4, 16'h0002);
    #1;
    vectors++; if (byp_hit_1 !== 1'b1 || byp_data_1 !== 16'h0001) begin miscompares++; $display("FAIL byp_first got=%b/%h exp=1/0001", byp_hit_1, byp_data_1); end
    tick();
    set_alu(1'b0, 3'd0, 16'h0);
    #1;
    vectors++; if (byp_hit_1 !== 1'b1 || byp_data_1 !== 16'h0002) begin miscompares++; $display("FAIL byp_youngest got=%b/%h exp=1/0002", byp_hit_1, byp_data_1); end
    vectors++; if (byp_hit_2 !== 1'b0 || byp_data_2 !== 16'h0) begin miscompares++; $display("FAIL byp_miss2 got=%b/%h exp=0/0000", byp_hit_2, byp_data_2); end
    byp_addr_2 = 3'd4;
    #1;
    vectors++; if (byp_hit_2 !== 1'b1 || byp_data_2 !== 16'h0002) begin miscompares++; $display("FAIL byp_shared got=%b/%h exp=1/0002", byp_hit_2, byp_data_2); end
    byp_addr_2 = 3'd6;
    tick();
    vectors++; if (rw_en !== 1'b1 || pending !== 4'd0 || byp_hit_1 !== 1'b1 || byp_data_1 !== 16'h0002) begin miscompares++; $display("FAIL byp_rwreg got rw_en=%b pending=%0d hit=%b data=%h exp=1/0/1/0002", rw_en, pending, byp_hit_1, byp_data_1); end
    tick();
    vectors++; if (byp_hit_1 !== 1'b0 || byp_data_1 !== 16'h0) begin miscompares++; $display("FAIL byp_gone got=%b/%h exp=0/0000", byp_hit_1, byp_data_1); end
  endtask

  task automatic test_reset_mid();
    byp_addr_1 = 3'd7;
    byp_addr_2 = 3'd1;
    set_mem(1'b1, 3'd7, 16'hDEAD);
    set_alu(1'b1, 3'd1, 16'hBEEF);
    tick();
    set_mem(1'b1, 3'd7, 16'hD00D);
    set_alu(1'b1, 3'd1, 16'hF00D);
    tick();
    set_mem(1'b0, 3'd0, 16'h0);
    set_alu(1'b0, 3'd0, 16'h0);
    vectors++; if (pending !== 4'd3) begin miscompares++; $display("FAIL rmid_pending got=%0d exp=3", pending); end
    rst_n = 1'b0;
    set_mem(1'b1, 3'd2, 16'h0BAD);
    set_alu(1'b1, 3'd2, 16'h0BAD);
    #1;
    vectors++; if ({mem_ready, alu_ready} !== 2'b00) begin miscompares++; $display("FAIL rmid_ready got=%b%b exp=00", mem_ready, alu_ready); end
    tick();
    set_mem(1'b0, 3'd0, 16'h0);
    set_alu(1'b0, 3'd0, 16'h0);
    vectors++; if (pending !== 4'd0 || rw_en !== 1'b0) begin miscompares++; $display("FAIL rmid_state got pending=%0d rw_en=%b exp=0/0", pending, rw_en); end
    vectors++; if ({byp_hit_1, byp_hit_2} !== 2'b00) begin miscompares++; $display("FAIL rmid_bypass got=%b%b exp=00", byp_hit_1, byp_hit_2); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (rw_en !== 1'b0 || pending !== 4'd0) begin miscompares++; $display("FAIL rmid_quiet%0d got rw_en=%b pending=%0d exp=0/0", i, rw_en, pending); end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW+DW-1:0] q [$];
    logic [AW+DW-1:0] head;
    logic [DW-1:0]    rf_model [8];
    logic [DW-1:0]    rf_dut [8];
    logic             hold_m, hold_a, em, ea, pop;
    int               free;
    for (int r = 0; r < 8; r++) begin rf_model[r] = '0; rf_dut[r] = '0; end
    hold_m = 1'b0; hold_a = 1'b0; head = '0;
    for (int cyc = 0; cyc < 110; cyc++) begin
      if (!hold_m) set_mem((cyc < 100) && ($urandom_range(3) != 0), AW'($urandom), DW'($urandom));
      if (!hold_a) set_alu((cyc < 100) && ($urandom_range(3) != 0), AW'($urandom), DW'($urandom));
      #1;
      free = 4 - q.size();
      em = (free >= 1);
      ea = (free >= 2) || ((free == 1) && !mem_valid);
      vectors++; if ({mem_ready, alu_ready} !== {em, ea}) begin miscompares++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", cyc, mem_ready, alu_ready, em, ea); end
      pop = (q.size() > 0);
      if (pop) head = q.pop_front();
      if (mem_valid && em) q.push_back({mem_dest, mem_data});
      if (alu_valid && ea) q.push_back({alu_dest, alu_data});
      hold_m = mem_valid && !em;
      hold_a = alu_valid && !ea;
      tick();
      vectors++; if (rw_en !== pop || (pop && {rw_dest, rw_data} !== head)) begin miscompares++; $display("FAIL rand_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, rw_en, rw_dest, rw_data, pop, head[AW+DW-1:DW], head[DW-1:0]); end
      vectors++; if (pending !== 4'(q.size()) || pending > 4'd4) begin miscompares++; $display("FAIL rand_pending cyc=%0d got=%0d exp=%0d", cyc, pending, q.size()); end
      if (pop) rf_model[head[AW+DW-1:DW]] = head[DW-1:0];
      if (rw_en) rf_dut[rw_dest] = rw_data;
    end
    for (int r = 0; r < 8; r++) begin
      vectors++; if (rf_dut[r] !== rf_model[r]) begin miscompares++; $display("FAIL rand_rf r%0d got=%h exp=%h", r, rf_dut[r], rf_model[r]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_mem(1'b0, 3'd0, 16'h0);
    set_alu(1'b0, 3'd0, 16'h0);
    byp_addr_1 = 3'd0;
    byp_addr_2 = 3'd0;
    test_reset();
    test_single_push();
    test_simultaneous();
    test_fill();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
